dmem_stall_ctrl: RTL



---
 rtl/dmem_stall_ctrl_if.sv | 37 +++
 rtl/dmem_stall_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_stall_ctrl_if
// Data-memory bus between the M-stage stall controller and the data memory.
//
//   mem_req    controller -> memory  request, held for the whole access
//   mem_we     controller -> memory  write enable, meaningful only with mem_req
//   mem_addr   controller -> memory  word address (bits [1:0] are always 0)
//   mem_wdata  controller -> memory  store data
//   mem_ready  memory -> controller  completion strobe
//   mem_rdata  memory -> controller  load data, valid together with mem_ready
// ---------------------------------------------------------------------------
interface dmem_stall_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_stall_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_stall_ctrl
// Holds the pipeline (F..M) while a load or store in the M stage talks to a
// variable-latency data memory. One access per M-stage instruction:
// IDLE -> ACCESS -> DONE, or IDLE -> DONE for a misaligned address. DONE
// releases the stall for exactly one cycle so the pipeline advances once.
//
// Parameter
//   TIMEOUT      ACCESS cycles allowed before the access is aborted (1..255)
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   MemReadM     load in M stage
//   MemWriteM    store in M stage (wins when both are high)
//   ALUResultM   byte address
//   WriteDataM   store data
//   mem          data-memory bus (master side)
//   StallM       combinational hold of pipeline registers F..M
//   ReadDataM    registered load result
//   timeout_err  sticky: an access timed out
//   misalign_err sticky: an access used a non-word-aligned address
// ---------------------------------------------------------------------------
module dmem_stall_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      MemReadM,
    input  logic                      MemWriteM,
    input  logic [31:0]               ALUResultM,
    input  logic [31:0]               WriteDataM,
    dmem_stall_ctrl_if.master         mem,
    output logic                      StallM,
    output logic [31:0]               ReadDataM,
    output logic                      timeout_err,
    output logic                      misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_inc;

    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_read_data;
    logic        r_timeout_err;
    logic        r_misalign_err;

    logic        w_op;
    logic        w_aligned;
    logic        w_start;
    logic        w_misalign;
    logic        w_complete;
    logic        w_timeout;
    logic        w_stall;

    assign w_op           = MemReadM | MemWriteM;
    assign w_aligned      = (ALUResultM[1:0] == 2'b00);
    assign w_wait_cnt_inc = r_wait_cnt + 8'd1;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle decisions.
    always_comb begin
        // NOTE: every output gets a default first; a path that skips an
        // assignment would otherwise infer a latch.
        w_state_next = r_state;
        w_start      = 1'b0;
        w_misalign   = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        w_stall      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_op) begin
                    w_stall = 1'b1;
                    if (w_aligned) begin
                        w_start      = 1'b1;
                        w_state_next = S_ACCESS;
                    end else begin
                        w_misalign   = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end
            S_ACCESS: begin
                w_stall = 1'b1;
                // Completion is tested first so a ready on the timeout edge
                // still counts as a good access.
                if (mem.mem_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = S_DONE;
                end else if (w_wait_cnt_inc == TIMEOUT) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Wait counter: cleared on ACCESS entry, counts ACCESS cycles without
    // mem_ready. TIMEOUT >= 1 guarantees the abort fires before it wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= 8'd0;
        end else if (w_start) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == S_ACCESS && !mem.mem_ready) begin
            r_wait_cnt <= w_wait_cnt_inc;
        end
    end

    // Memory bus registers. Address, data and we only change on ACCESS entry,
    // so they stay stable for the whole access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else if (w_start) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= MemWriteM;
            r_mem_addr  <= {ALUResultM[31:2], 2'b00};
            r_mem_wdata <= WriteDataM;
        end else if (w_complete || w_timeout) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
        end
    end

    // Load result and sticky error flags. r_mem_we still holds the access
    // kind on the completion edge, so it tells loads from stores.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_read_data    <= 32'd0;
            r_timeout_err  <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            if (w_misalign || w_timeout) begin
                r_read_data <= 32'd0;
            end else if (w_complete && !r_mem_we) begin
                r_read_data <= mem.mem_rdata;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (w_misalign) begin
                r_misalign_err <= 1'b1;
            end
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;

    assign StallM        = w_stall;
    assign ReadDataM     = r_read_data;
    assign timeout_err   = r_timeout_err;
    assign misalign_err  = r_misalign_err;

endmodule
